biu_arbiter: RTL and testbench
==============================

Name: biu_arbiter

Overview:
- Shares one memory bus interface (BIU) port between the core's data-memory requester (port 0, dmem_*) and instruction-fetch requester (port 1).
- Fixed priority goes to data, with a starvation guard that promotes instruction fetch.
- Sits between the core and the single external memory/BIU port.
- Allows exactly one outstanding transaction, and adds a watchdog that returns a bus error if the slave never responds.

Parameters:
XLEN, 32, address/data width
STARVE_LIMIT, 4, consecutive lost arbitrations by port 1 before it wins over port 0 (0 = pure fixed priority)
TIMEOUT, 255, cycles in BUSY without s_ack/s_err before error is forced (0 = watchdog disabled)

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
m0_req  input  1  data port request, held until m0_ack/m0_err
m0_adr  input  XLEN  data port address
m0_d  input  XLEN  data port write data
m0_we  input  1  data port write enable
m0_size  input  biu_size_t  data port transfer size
m0_q  output  XLEN  data port read data
m0_ack  output  1  data port completion
m0_err  output  1  data port error completion
m1_req, m1_adr, m1_d, m1_we, m1_size, m1_q, m1_ack, m1_err  as m0_*, for the instruction port
s_req  output  1  request to memory
s_adr  output  XLEN  address to memory
s_d  output  XLEN  write data to memory
s_we  output  1  write enable to memory
s_size  output  biu_size_t  size to memory
s_q  input  XLEN  read data from memory
s_ack  input  1  memory completion
s_err  input  1  memory error
busy  output  1  transaction outstanding
grant  output  2  one-hot owner of current transaction ({m1,m0}), 0 when idle

Behaviour:
- Reset (async, rstn=0): state=IDLE; s_req, s_we, busy, grant, and the starvation and watchdog counters all 0; s_adr/s_d/s_size 0. m*_ack/m*_err are 0 because grant=0. Reset mid-transaction drops s_req immediately. A slave response arriving after reset is ignored.
- States: IDLE, BUSY.
- IDLE:
  - If either m*_req is high, select the winner. Port 0 wins unless m1_req=1 and starve_cnt>=STARVE_LIMIT with STARVE_LIMIT!=0. A lone requester always wins.
  - On the next edge, register the winner's adr/d/we/size into the s_* outputs, set s_req=1, busy=1, grant=winner, and go to BUSY.
  - Latency is 1 cycle from m*_req to s_req.
- BUSY:
  - s_* outputs are stable and s_req stays high.
  - m_x_q = s_q for the granted port; the non-granted port's m_q = 0.
  - m_x_ack = s_ack & grant[x] and m_x_err = s_err & grant[x], both combinational with the same cycle as the slave.
  - On s_ack|s_err: next edge s_req=0, busy=0, grant=0, go to IDLE.
  - Minimum one idle cycle between transactions, giving back-to-back throughput of one transfer per (slave latency + 1) cycles.
  - s_ack and s_err together: both are passed through; treated as an error completion by the master.
- Starvation counter:
  - Width $clog2(STARVE_LIMIT+1); saturates at STARVE_LIMIT.
  - Increments on each IDLE arbitration where m1_req=1 and port 0 wins.
  - Clears when port 1 is granted.
  - Unchanged otherwise.
- Watchdog:
  - Counts cycles in BUSY and clears on entering BUSY.
  - When TIMEOUT!=0, count==TIMEOUT, and there is no s_ack/s_err that cycle: assert m_x_err for the granted port for exactly that cycle, then next edge s_req=0 and go to IDLE.
  - A late s_ack/s_err received while IDLE is ignored, producing no m*_ack/err.
- Master dropping m*_req before completion is a protocol violation. The transaction still completes and the ack is still delivered.
- Requests are sampled only in IDLE. A request arriving during BUSY waits.

Test Plan:
- Reset check: rstn=0 mid-BUSY with s_req=1 -> s_req=0, busy=0, grant=0 immediately; s_ack pulse while rstn=0 produces no m0_ack/m1_ack.
- Single read: m0_req=1, m0_adr=0x100, m0_we=0, size WORD; slave acks 2 cycles after s_req with s_q=0xDEADBEEF -> s_req rises 1 cycle after m0_req, s_adr=0x100, m0_ack=1 with m0_q=0xDEADBEEF in the s_ack cycle, busy=0 next cycle.
- Fixed priority: m0_req and m1_req both held, slave acks in 1 cycle -> grant=01 for 4 consecutive transactions; 5th grant=10 (STARVE_LIMIT=4); following grant=01.
- STARVE_LIMIT=0: both requesting continuously for 10 transactions -> port 1 never granted.
- Timeout: TIMEOUT=8, m1_req=1, slave silent -> m1_err=1 exactly on the 9th BUSY cycle, s_req=0 next cycle; subsequent late s_ack -> no m0_ack/m1_ack.
- Write passthrough: m1_req with m1_we=1, m1_d=0x12345678, m1_adr=0x200 -> s_we=1, s_d=0x12345678, s_adr=0x200 stable until s_ack; m0_ack stays 0 throughout.

Source files
------------

// File: rtl/biu_arbiter.sv
// Shares one BIU slave port between data (m0) and ifetch (m1) masters; s_req rises 1 cycle after an IDLE request.
// One outstanding transfer; masters hold req until ack/err, losers wait; watchdog forces err on a silent slave.
package biu_pkg;
  typedef enum logic [1:0] {
    BIU_BYTE = 2'd0,
    BIU_HALF = 2'd1,
    BIU_WORD = 2'd2
  } biu_size_t;
endpackage

module biu_arbiter
  import biu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            m0_req,
  input  logic [XLEN-1:0] m0_adr,
  input  logic [XLEN-1:0] m0_d,
  input  logic            m0_we,
  input  biu_size_t       m0_size,
  output logic [XLEN-1:0] m0_q,
  output logic            m0_ack,
  output logic            m0_err,
  input  logic            m1_req,
  input  logic [XLEN-1:0] m1_adr,
  input  logic [XLEN-1:0] m1_d,
  input  logic            m1_we,
  input  biu_size_t       m1_size,
  output logic [XLEN-1:0] m1_q,
  output logic            m1_ack,
  output logic            m1_err,
  output logic            s_req,
  output logic [XLEN-1:0] s_adr,
  output logic [XLEN-1:0] s_d,
  output logic            s_we,
  output biu_size_t       s_size,
  input  logic [XLEN-1:0] s_q,
  input  logic            s_ack,
  input  logic            s_err,
  output logic            busy,
  output logic [1:0]      grant
);
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] WD_MAX     = TW'(TIMEOUT);
  localparam logic [0:0]    S_IDLE     = 1'b0;
  localparam logic [0:0]    S_BUSY     = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [TW-1:0]   wd_q, wd_d;
  logic [XLEN-1:0] adr_q, adr_d;
  logic [XLEN-1:0] dat_q, dat_d;
  logic            we_q, we_d;
  biu_size_t       size_q, size_d;
  logic            starve_hit, pick1, wd_fire, done;

  always_comb begin
    // Counter saturates at the limit, so equality is the ">= limit" test.
    starve_hit = (STARVE_LIMIT != 0) && (starve_q == STARVE_MAX);
    pick1      = m1_req & (~m0_req | starve_hit);
    wd_fire    = (TIMEOUT != 0) && (state_q == S_BUSY) && (wd_q == WD_MAX) && !s_ack && !s_err;
    done       = s_ack | s_err | wd_fire;

    state_d  = state_q;
    grant_d  = grant_q;
    starve_d = starve_q;
    wd_d     = wd_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    size_d   = size_q;

    case (state_q)
      S_IDLE: begin
        if (m0_req | m1_req) begin
          state_d = S_BUSY;
          wd_d    = '0;
          grant_d = pick1 ? 2'b10 : 2'b01;
          adr_d   = pick1 ? m1_adr  : m0_adr;
          dat_d   = pick1 ? m1_d    : m0_d;
          we_d    = pick1 ? m1_we   : m0_we;
          size_d  = pick1 ? m1_size : m0_size;
          if (pick1) begin
            starve_d = '0;
          end else if (m1_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      default: begin
        wd_d = wd_q + TW'(1);
        if (done) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          we_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      grant_q  <= 2'b00;
      starve_q <= '0;
      wd_q     <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= BIU_BYTE;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      wd_q     <= wd_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      size_q   <= size_d;
    end
  end

  assign s_req  = (state_q == S_BUSY);
  assign busy   = s_req;
  assign grant  = grant_q;
  assign s_adr  = adr_q;
  assign s_d    = dat_q;
  assign s_we   = we_q;
  assign s_size = size_q;

  // grant is zero in IDLE, so late or stray slave responses never reach a master.
  assign m0_q   = grant_q[0] ? s_q : '0;
  assign m1_q   = grant_q[1] ? s_q : '0;
  assign m0_ack = s_ack & grant_q[0];
  assign m1_ack = s_ack & grant_q[1];
  assign m0_err = (s_err | wd_fire) & grant_q[0];
  assign m1_err = (s_err | wd_fire) & grant_q[1];
endmodule

// File: tb/tb_biu_arbiter.sv
// Bench for biu_arbiter: dut A (starve limit 4, timeout 8) and dut B (pure fixed priority) on shared stimulus.
module tb_biu_arbiter;
  import biu_pkg::*;
  localparam int XLEN       = 32;
  localparam int TB_STARVE  = 4;
  localparam int TB_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rstn;
  logic m0_req, m0_we, m1_req, m1_we, s_ack, s_err;
  logic [XLEN-1:0] m0_adr, m0_d, m1_adr, m1_d, s_q;
  biu_size_t m0_size, m1_size;

  logic [XLEN-1:0] m0_q, m1_q, s_adr, s_d;
  logic m0_ack, m0_err, m1_ack, m1_err, s_req, s_we, busy;
  biu_size_t s_size;
  logic [1:0] grant;

  logic [XLEN-1:0] b_m0_q, b_m1_q, b_s_adr, b_s_d;
  logic b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_req, b_s_we, b_busy;
  biu_size_t b_s_size;
  logic [1:0] b_grant;

  int checks = 0;
  int errors = 0;
  int mdl_starve = 0;
  int b_starve = 0;

  always #5 clk = ~clk;

  biu_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(TB_STARVE), .TIMEOUT(TB_TIMEOUT)) u_dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_adr(m0_adr), .m0_d(m0_d), .m0_we(m0_we), .m0_size(m0_size),
    .m0_q(m0_q), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_adr(m1_adr), .m1_d(m1_d), .m1_we(m1_we), .m1_size(m1_size),
    .m1_q(m1_q), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_req(s_req), .s_adr(s_adr), .s_d(s_d), .s_we(s_we), .s_size(s_size),
    .s_q(s_q), .s_ack(s_ack), .s_err(s_err), .busy(busy), .grant(grant)
  );

  biu_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(0), .TIMEOUT(TB_TIMEOUT)) u_dut_fixed (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_adr(m0_adr), .m0_d(m0_d), .m0_we(m0_we), .m0_size(m0_size),
    .m0_q(b_m0_q), .m0_ack(b_m0_ack), .m0_err(b_m0_err),
    .m1_req(m1_req), .m1_adr(m1_adr), .m1_d(m1_d), .m1_we(m1_we), .m1_size(m1_size),
    .m1_q(b_m1_q), .m1_ack(b_m1_ack), .m1_err(b_m1_err),
    .s_req(b_s_req), .s_adr(b_s_adr), .s_d(b_s_d), .s_we(b_s_we), .s_size(b_s_size),
    .s_q(s_q), .s_ack(s_ack), .s_err(s_err), .busy(b_busy), .grant(b_grant)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule: data wins unless ifetch has lost `limit` times in a row.
  task automatic model_arb(input bit r0, input bit r1, input int limit, inout int cnt, output logic [1:0] g);
    if (r1 && (!r0 || (limit != 0 && cnt >= limit))) begin
      g = 2'b10;
      cnt = 0;
    end else begin
      g = 2'b01;
      if (r1 && cnt < limit) cnt = cnt + 1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_q = '0;
    m0_req = 1'b0; m0_adr = '0; m0_d = '0; m0_we = 1'b0; m0_size = BIU_WORD;
    m1_req = 1'b0; m1_adr = '0; m1_d = '0; m1_we = 1'b0; m1_size = BIU_WORD;
    repeat (2) step();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rst_s_req: got %b exp 0", s_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b exp 00", grant); end
    checks++; if ({s_adr, s_d, s_we, s_size} !== '0) begin errors++; $display("FAIL rst_s_fields: got %h %h %b %0d exp 0", s_adr, s_d, s_we, s_size); end
    rstn = 1'b1; mdl_starve = 0; b_starve = 0;
    m0_req = 1'b1; m0_adr = 32'h40;
    step();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b exp 1", s_req); end
    rstn = 1'b0;
    #1;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rst_mid_s_req: got %b exp 0", s_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b exp 0", busy); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_mid_grant: got %b exp 00", grant); end
    s_ack = 1'b1; s_q = 32'hFFFF_FFFF;
    #1;
    checks++; if ({m0_ack, m1_ack} !== 2'b00) begin errors++; $display("FAIL rst_ack_ignored: got %b exp 00", {m0_ack, m1_ack}); end
    m0_req = 1'b0;
    step();
    s_ack = 1'b0; s_q = '0; rstn = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_after_busy: got %b exp 0", busy); end
  endtask

  task automatic test_single_read();
    logic [1:0] eg, ebg;
    m0_req = 1'b1; m0_adr = 32'h100; m0_we = 1'b0; m0_size = BIU_WORD; m0_d = $urandom;
    model_arb(1'b1, 1'b0, TB_STARVE, mdl_starve, eg);
    model_arb(1'b1, 1'b0, 0, b_starve, ebg);
    #1;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rd_early_s_req: got %b exp 0", s_req); end
    step();
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL rd_s_req: got %b exp 1", s_req); end
    checks++; if (s_adr !== 32'h100) begin errors++; $display("FAIL rd_s_adr: got %h exp 100", s_adr); end
    checks++; if ({s_we, s_size} !== {1'b0, BIU_WORD}) begin errors++; $display("FAIL rd_we_size: got %b %0d exp 0 2", s_we, s_size); end
    checks++; if (grant !== eg) begin errors++; $display("FAIL rd_grant: got %b exp %b", grant, eg); end
    step();
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL rd_early_ack: got %b exp 0", m0_ack); end
    step();
    s_ack = 1'b1; s_q = 32'hDEAD_BEEF;
    #1;
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL rd_m0_ack: got %b exp 1", m0_ack); end
    checks++; if (m0_q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_m0_q: got %h exp deadbeef", m0_q); end
    checks++; if ({m1_ack, m1_q} !== '0) begin errors++; $display("FAIL rd_m1_quiet: got %b %h exp 0 0", m1_ack, m1_q); end
    step();
    m0_req = 1'b0; s_ack = 1'b0; s_q = '0;
    checks++; if ({busy, s_req, grant} !== 4'b0) begin errors++; $display("FAIL rd_done: got %b exp 0000", {busy, s_req, grant}); end
  endtask

  task automatic test_fixed_priority();
    m0_req = 1'b1; m0_adr = 32'h300; m1_req = 1'b1; m1_adr = 32'h400;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] eg, ebg;
      model_arb(m0_req, m1_req, TB_STARVE, mdl_starve, eg);
      model_arb(m0_req, m1_req, 0, b_starve, ebg);
      step();
      checks++; if (grant !== eg) begin errors++; $display("FAIL prio_grant[%0d]: got %b exp %b", i, grant, eg); end
      checks++; if (b_grant !== ebg) begin errors++; $display("FAIL prio_b_grant[%0d]: got %b exp %b", i, b_grant, ebg); end
      checks++; if (s_adr !== (eg[1] ? m1_adr : m0_adr)) begin errors++; $display("FAIL prio_s_adr[%0d]: got %h", i, s_adr); end
      s_ack = 1'b1; s_q = XLEN'(i);
      #1;
      checks++; if ({m1_ack, m0_ack} !== eg) begin errors++; $display("FAIL prio_ack[%0d]: got %b exp %b", i, {m1_ack, m0_ack}, eg); end
      step();
      s_ack = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_idle_gap[%0d]: got %b exp 0", i, busy); end
    end
  endtask

  task automatic test_pure_fixed();
    for (int i = 0; i < 10; i++) begin
      logic [1:0] eg, ebg;
      model_arb(m0_req, m1_req, TB_STARVE, mdl_starve, eg);
      model_arb(m0_req, m1_req, 0, b_starve, ebg);
      step();
      checks++; if (b_grant !== ebg) begin errors++; $display("FAIL fixed_b_grant[%0d]: got %b exp %b", i, b_grant, ebg); end
      checks++; if (grant !== eg) begin errors++; $display("FAIL fixed_a_grant[%0d]: got %b exp %b", i, grant, eg); end
      s_ack = 1'b1;
      #1;
      checks++; if (b_m1_ack !== 1'b0) begin errors++; $display("FAIL fixed_b_m1_ack[%0d]: got %b exp 0", i, b_m1_ack); end
      step();
      s_ack = 1'b0;
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_timeout();
    logic [1:0] eg, ebg;
    m1_req = 1'b1; m1_adr = 32'h500; m1_we = 1'b0;
    model_arb(1'b0, 1'b1, TB_STARVE, mdl_starve, eg);
    model_arb(1'b0, 1'b1, 0, b_starve, ebg);
    step();
    checks++; if (grant !== eg) begin errors++; $display("FAIL to_grant: got %b exp %b", grant, eg); end
    for (int k = 1; k <= TB_TIMEOUT + 1; k++) begin
      checks++; if (m1_err !== (k == TB_TIMEOUT + 1)) begin errors++; $display("FAIL to_m1_err[cycle %0d]: got %b", k, m1_err); end
      checks++; if (b_m1_err !== (k == TB_TIMEOUT + 1)) begin errors++; $display("FAIL to_b_m1_err[cycle %0d]: got %b", k, b_m1_err); end
      checks++; if ({s_req, m0_err} !== 2'b10) begin errors++; $display("FAIL to_busy[cycle %0d]: got %b exp 10", k, {s_req, m0_err}); end
      step();
    end
    m1_req = 1'b0;
    checks++; if ({s_req, busy} !== 2'b00) begin errors++; $display("FAIL to_release: got %b exp 00", {s_req, busy}); end
    s_ack = 1'b1;
    #1;
    checks++; if ({m0_ack, m1_ack, m1_err} !== 3'b000) begin errors++; $display("FAIL to_late_ack: got %b exp 000", {m0_ack, m1_ack, m1_err}); end
    step();
    s_ack = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_late_idle: got %b exp 0", busy); end
  endtask

  task automatic test_write();
    logic [1:0] eg, ebg;
    m1_req = 1'b1; m1_we = 1'b1; m1_d = 32'h1234_5678; m1_adr = 32'h200; m1_size = BIU_HALF;
    model_arb(1'b0, 1'b1, TB_STARVE, mdl_starve, eg);
    model_arb(1'b0, 1'b1, 0, b_starve, ebg);
    step();
    for (int j = 0; j < 3; j++) begin
      checks++; if ({s_we, s_d, s_adr, s_size} !== {1'b1, 32'h1234_5678, 32'h200, BIU_HALF}) begin errors++; $display("FAIL wr_fields[%0d]: got %b %h %h %0d", j, s_we, s_d, s_adr, s_size); end
      checks++; if ({grant, m0_ack} !== {eg, 1'b0}) begin errors++; $display("FAIL wr_grant_m0[%0d]: got %b exp %b0", j, {grant, m0_ack}, eg); end
      step();
    end
    s_ack = 1'b1;
    #1;
    checks++; if ({m1_ack, m0_ack} !== 2'b10) begin errors++; $display("FAIL wr_ack: got %b exp 10", {m1_ack, m0_ack}); end
    step();
    s_ack = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_done: got %b exp 0", busy); end
  endtask

  // Randomised traffic: both masters request at will, the slave answers after 0-3 cycles with ack/err/both.
  task automatic test_random();
    bit mb = 1'b0;
    logic [1:0] mg = 2'b00;
    logic [XLEN-1:0] ma = '0, md = '0;
    logic mwe = 1'b0;
    biu_size_t msz = BIU_BYTE;
    int lat = 0;
    int r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [XLEN-1:0] e_q0, e_q1;
      logic e_a0, e_e0, e_a1, e_e1;
      checks++; if (s_req !== mb) begin errors++; $display("FAIL rnd_s_req[%0d]: got %b exp %b", cyc, s_req, mb); end
      checks++; if (grant !== (mb ? mg : 2'b00)) begin errors++; $display("FAIL rnd_grant[%0d]: got %b exp %b", cyc, grant, mb ? mg : 2'b00); end
      if (mb) begin
        checks++; if ({s_adr, s_d, s_we, s_size} !== {ma, md, mwe, msz}) begin errors++; $display("FAIL rnd_fields[%0d]: got %h %h %b %0d exp %h %h %b %0d", cyc, s_adr, s_d, s_we, s_size, ma, md, mwe, msz); end
      end
      s_ack = 1'b0; s_err = 1'b0; s_q = $urandom;
      if (mb) begin
        if (lat == 0) begin
          r = $urandom_range(0, 19);
          s_ack = (r < 16) || (r == 19);
          s_err = (r >= 16);
        end else begin
          lat = lat - 1;
        end
      end
      #1;
      e_a0 = mb && mg[0] && s_ack;  e_e0 = mb && mg[0] && s_err;  e_q0 = (mb && mg[0]) ? s_q : '0;
      e_a1 = mb && mg[1] && s_ack;  e_e1 = mb && mg[1] && s_err;  e_q1 = (mb && mg[1]) ? s_q : '0;
      checks++; if ({m0_ack, m0_err, m0_q} !== {e_a0, e_e0, e_q0}) begin errors++; $display("FAIL rnd_m0[%0d]: got %b %b %h exp %b %b %h", cyc, m0_ack, m0_err, m0_q, e_a0, e_e0, e_q0); end
      checks++; if ({m1_ack, m1_err, m1_q} !== {e_a1, e_e1, e_q1}) begin errors++; $display("FAIL rnd_m1[%0d]: got %b %b %h exp %b %b %h", cyc, m1_ack, m1_err, m1_q, e_a1, e_e1, e_q1); end
      if (mb && (s_ack || s_err)) begin
        mb = 1'b0;
        if (mg[0]) m0_req = 1'b0; else m1_req = 1'b0;
      end
      if (!m0_req && cyc < 380 && $urandom_range(0, 1) == 0) begin
        m0_req = 1'b1; m0_adr = $urandom; m0_d = $urandom; m0_we = 1'($urandom_range(0, 1)); m0_size = biu_size_t'(2'($urandom_range(0, 2)));
      end
      if (!m1_req && cyc < 380 && $urandom_range(0, 1) == 0) begin
        m1_req = 1'b1; m1_adr = $urandom; m1_d = $urandom; m1_we = 1'($urandom_range(0, 1)); m1_size = biu_size_t'(2'($urandom_range(0, 2)));
      end
      if (!mb && !s_req && (m0_req || m1_req)) begin
        model_arb(m0_req, m1_req, TB_STARVE, mdl_starve, mg);
        mb = 1'b1;
        ma  = mg[1] ? m1_adr  : m0_adr;
        md  = mg[1] ? m1_d    : m0_d;
        mwe = mg[1] ? m1_we   : m0_we;
        msz = mg[1] ? m1_size : m0_size;
        lat = $urandom_range(0, 3);
      end else if (!mb && s_req) begin
        // Model is idle this cycle but the DUT is still busy: keep the model idle and let the check flag it.
        lat = 0;
      end
      step();
    end
    s_ack = 1'b0; s_err = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fixed_priority();
    test_pure_fixed();
    test_timeout();
    test_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
